// File: rtl/stall_report_packetizer_pkg.sv
// Shared types and constants for the stall report packetizer.
// Frame layout: sync byte, big-endian counter payload, XOR checksum of the payload.
package stall_report_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HEADER   = 2'd1,
    PAYLOAD  = 2'd2,
    CHECKSUM = 2'd3
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Total bytes on the wire for a frame of n counters.
  function automatic int frame_bytes(input int n);
    return 4 * n + 2;
  endfunction

endpackage

// File: rtl/stall_report_packetizer_if.sv
// Byte stream towards the debug UART transmitter.
// Handshake: a byte moves when tx_valid && tx_ready at a clk edge; while tx_valid is
// high and no transfer has happened, tx_data is held stable and tx_valid stays high.
interface stall_report_packetizer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/stall_report_packetizer_byte_sel.sv
// Picks payload byte idx from the frozen snapshot: counter idx/4, MSB first.
module report_byte_sel #(
  parameter int NUM_COUNTERS = 9,
  parameter int IDX_W        = 6
) (
  input  logic [NUM_COUNTERS*32-1:0] i_snapshot,
  input  logic [IDX_W-1:0]           i_idx,
  output logic [7:0]                 o_byte
);

  always_comb begin
    o_byte = '0;
    for (int k = 0; k < 4 * NUM_COUNTERS; k++) begin
      if (i_idx == IDX_W'(k)) begin
        o_byte = i_snapshot[(k / 4) * 32 + (3 - (k % 4)) * 8 +: 8];
      end
    end
  end

endmodule

// File: rtl/stall_report_packetizer.sv
// Freezes the stall counters on a trigger and serializes them as a framed byte stream.
// One request can queue behind the frame in flight; further ones are counted as drops.
module stall_report_packetizer
  import stall_report_pkg::*;
#(
  parameter int         NUM_COUNTERS = 9,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      trigger,
  input  logic [NUM_COUNTERS*32-1:0] counters,
  stall_report_packetizer_if.master tx,
  output logic                      busy,
  output logic                      frame_done,
  output logic [7:0]                drop_count,
  output state_t                    dbg_state
);

  localparam int               IDX_W    = $clog2(4 * NUM_COUNTERS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(4 * NUM_COUNTERS - 1);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [NUM_COUNTERS*32-1:0] r_snapshot;
  logic [IDX_W-1:0]          r_idx;
  logic [IDX_W-1:0]          w_idx_nxt;
  logic [7:0]                r_checksum;
  logic [7:0]                w_checksum_nxt;
  logic                      r_pending;
  logic                      w_pending_nxt;
  logic [7:0]                r_drop_count;
  logic [7:0]                w_drop_nxt;
  logic [7:0]                r_tx_data;
  logic [7:0]                w_tx_data_nxt;
  logic                      r_tx_valid;
  logic [7:0]                w_sel_byte;
  logic                      w_xfer;
  logic                      w_clear;
  logic                      w_start;
  logic                      w_last;

  assign w_clear = rst || !enable;
  assign w_xfer  = r_tx_valid && tx.tx_ready;
  assign w_start = (r_state == IDLE) && (trigger || r_pending);
  assign w_last  = (r_idx == LAST_IDX);

  // State register
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (trigger || r_pending) w_state_nxt = HEADER;
      HEADER:   if (w_xfer) w_state_nxt = PAYLOAD;
      PAYLOAD:  if (w_xfer && w_last) w_state_nxt = CHECKSUM;
      CHECKSUM: if (w_xfer) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  // Datapath next values: byte index, running checksum, request bookkeeping
  always_comb begin
    w_idx_nxt      = r_idx;
    w_checksum_nxt = r_checksum;
    w_pending_nxt  = r_pending;
    w_drop_nxt     = r_drop_count;

    if (w_start) begin
      w_checksum_nxt = '0;
    end
    if (r_state == HEADER) begin
      w_idx_nxt = '0;
    end
    if ((r_state == PAYLOAD) && w_xfer) begin
      w_checksum_nxt = r_checksum ^ r_tx_data;
      if (!w_last) begin
        w_idx_nxt = r_idx + 1'b1;
      end
    end

    // A trigger arriving in the same cycle a pending request is consumed stays queued.
    if (r_state == IDLE) begin
      w_pending_nxt = r_pending && trigger;
    end else if (trigger) begin
      if (!r_pending) begin
        w_pending_nxt = 1'b1;
      end else if (r_drop_count != 8'hFF) begin
        w_drop_nxt = r_drop_count + 8'd1;
      end
    end
  end

  report_byte_sel #(
    .NUM_COUNTERS (NUM_COUNTERS),
    .IDX_W        (IDX_W)
  ) u_byte_sel (
    .i_snapshot (r_snapshot),
    .i_idx      (w_idx_nxt),
    .o_byte     (w_sel_byte)
  );

  // Output logic: the byte to present after this edge, plus status outputs
  always_comb begin
    w_tx_data_nxt = '0;
    case (w_state_nxt)
      HEADER:   w_tx_data_nxt = SYNC_BYTE;
      PAYLOAD:  w_tx_data_nxt = w_sel_byte;
      CHECKSUM: w_tx_data_nxt = w_checksum_nxt;
      default:  w_tx_data_nxt = '0;
    endcase
    busy       = (r_state != IDLE);
    frame_done = (r_state == CHECKSUM) && w_xfer && !w_clear;
  end

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_snapshot   <= '0;
      r_idx        <= '0;
      r_checksum   <= '0;
      r_pending    <= 1'b0;
      r_drop_count <= '0;
      r_tx_data    <= '0;
      r_tx_valid   <= 1'b0;
    end else begin
      if (w_start) begin
        r_snapshot <= counters;
      end
      r_idx        <= w_idx_nxt;
      r_checksum   <= w_checksum_nxt;
      r_pending    <= w_pending_nxt;
      r_drop_count <= w_drop_nxt;
      r_tx_data    <= w_tx_data_nxt;
      r_tx_valid   <= (w_state_nxt != IDLE);
    end
  end

  assign tx.tx_data  = r_tx_data;
  assign tx.tx_valid = r_tx_valid;
  assign drop_count  = r_drop_count;
  assign dbg_state   = r_state;

endmodule
